// File: rtl/ex_mem_stage_n.sv
// EX->MEM pipeline register for a multi-lane issue machine. Resolves the oldest
// mispredicting lane, squashes younger lanes and emits a one-cycle redirect pulse.
module ex_mem_stage_n #(
  parameter int LANES     = 2,
  parameter int PAYLOAD_W = 128,
  parameter int CNT_W     = 32,
  parameter int LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       pause,
  input  logic [LANES-1:0]           lane_valid_i,
  input  logic [LANES*PAYLOAD_W-1:0] lane_payload_i,
  input  logic [LANES-1:0]           lane_mispred_i,
  input  logic [LANES*32-1:0]        lane_target_i,
  input  logic [LANES-1:0]           lane_pause_i,
  output logic                       pause_ex_o,
  output logic                       branch_flush_o,
  output logic [31:0]                branch_target_o,
  output logic [LW-1:0]              branch_lane_o,
  output logic [LANES-1:0]           mem_valid_o,
  output logic [LANES*PAYLOAD_W-1:0] mem_payload_o,
  output logic [CNT_W-1:0]           redirect_cnt_o,
  output logic [CNT_W-1:0]           squash_cnt_o
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t                     state_reg, state_next;
  logic [LANES-1:0]           hit;
  logic                       win_found;
  logic [LW-1:0]              win_idx;
  logic [31:0]                win_target;
  logic [LANES-1:0]           kill;
  logic [LANES-1:0]           keep;
  logic [LANES-1:0]           squashed;
  logic [3:0]                 squash_n;
  logic [LANES*PAYLOAD_W-1:0] payload_next;
  logic                       capture;
  logic                       fire;
  logic                       take;
  logic [31:0]                fire_target;
  logic [LW-1:0]              fire_lane;
  logic [31:0]                pend_target_reg;
  logic [LW-1:0]              pend_lane_reg;

  assign hit = lane_valid_i & lane_mispred_i;

  // Oldest hit wins; every lane after the first hit is younger and gets killed.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_target = '0;
    kill       = '0;
    for (int k = 0; k < LANES; k++) begin
      kill[k] = win_found;
      if (hit[k] && !win_found) begin
        win_idx    = LW'(k);
        win_target = lane_target_i[k*32 +: 32];
      end
      win_found = win_found | hit[k];
    end
  end

  assign keep       = lane_valid_i & ~kill;
  assign squashed   = lane_valid_i & kill;
  assign pause_ex_o = |(lane_pause_i & keep);
  assign capture    = !flush && !pause;

  always_comb begin
    squash_n = '0;
    for (int k = 0; k < LANES; k++) begin
      squash_n = squash_n + {3'b000, squashed[k]};
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign payload_next[gi*PAYLOAD_W +: PAYLOAD_W] =
        keep[gi] ? lane_payload_i[gi*PAYLOAD_W +: PAYLOAD_W] : '0;
    end
  endgenerate

  // Redirect FSM: a mispredict seen during a stall is parked in PEND until the stall clears.
  always_comb begin
    state_next  = state_reg;
    fire        = 1'b0;
    take        = 1'b0;
    fire_target = pend_target_reg;
    fire_lane   = pend_lane_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            if (!pause) begin
              fire        = 1'b1;
              fire_target = win_target;
              fire_lane   = win_idx;
            end else begin
              take       = 1'b1;
              state_next = PEND;
            end
          end
        end
        PEND: begin
          if (!pause) begin
            fire       = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      branch_flush_o  <= 1'b0;
      branch_target_o <= '0;
      branch_lane_o   <= '0;
      pend_target_reg <= '0;
      pend_lane_reg   <= '0;
      redirect_cnt_o  <= '0;
      squash_cnt_o    <= '0;
      mem_valid_o     <= '0;
      mem_payload_o   <= '0;
    end else begin
      state_reg      <= state_next;
      branch_flush_o <= fire;
      if (fire) begin
        branch_target_o <= fire_target;
        branch_lane_o   <= fire_lane;
        redirect_cnt_o  <= redirect_cnt_o + CNT_W'(1);
      end
      if (take) begin
        pend_target_reg <= win_target;
        pend_lane_reg   <= win_idx;
      end
      if (capture) begin
        squash_cnt_o <= squash_cnt_o + CNT_W'(squash_n);
      end
      if (flush) begin
        mem_valid_o   <= '0;
        mem_payload_o <= '0;
      end else if (!pause) begin
        mem_valid_o   <= keep;
        mem_payload_o <= payload_next;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage_n.sv
// Bench for ex_mem_stage_n: directed table, multi-cycle corner sequences on three
// parameterisations, and a randomized run against a behavioural model.
module tb_ex_mem_stage_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] PL0 = 128'hAAAA_0000_1111_2222_3333_4444_5555_0000;
  localparam logic [127:0] PL1 = 128'hBBBB_1111_6666_7777_8888_9999_CCCC_0001;
  localparam logic [31:0]  T0  = 32'h1C00_0040;
  localparam logic [31:0]  T1  = 32'h2000_0080;

  // main instance: LANES=2, default widths
  logic         a_rst, a_flush, a_pause;
  logic [1:0]   a_v, a_mp, a_lp;
  logic [255:0] a_pl;
  logic [63:0]  a_tg;
  logic         a_px, a_bf;
  logic [31:0]  a_bt;
  logic [0:0]   a_bl;
  logic [1:0]   a_mv;
  logic [255:0] a_mpl;
  logic [31:0]  a_rc, a_sc;

  ex_mem_stage_n #(.LANES(2), .PAYLOAD_W(128), .CNT_W(32)) u_dut (
    .clk(clk), .rst(a_rst), .flush(a_flush), .pause(a_pause),
    .lane_valid_i(a_v), .lane_payload_i(a_pl), .lane_mispred_i(a_mp),
    .lane_target_i(a_tg), .lane_pause_i(a_lp), .pause_ex_o(a_px),
    .branch_flush_o(a_bf), .branch_target_o(a_bt), .branch_lane_o(a_bl),
    .mem_valid_o(a_mv), .mem_payload_o(a_mpl), .redirect_cnt_o(a_rc), .squash_cnt_o(a_sc)
  );

  // four-lane instance
  logic         b_rst, b_flush, b_pause;
  logic [3:0]   b_v, b_mp, b_lp;
  logic [63:0]  b_pl;
  logic [127:0] b_tg;
  logic         b_px, b_bf;
  logic [31:0]  b_bt;
  logic [1:0]   b_bl;
  logic [3:0]   b_mv;
  logic [63:0]  b_mpl;
  logic [31:0]  b_rc, b_sc;

  ex_mem_stage_n #(.LANES(4), .PAYLOAD_W(16), .CNT_W(32)) u_dut4 (
    .clk(clk), .rst(b_rst), .flush(b_flush), .pause(b_pause),
    .lane_valid_i(b_v), .lane_payload_i(b_pl), .lane_mispred_i(b_mp),
    .lane_target_i(b_tg), .lane_pause_i(b_lp), .pause_ex_o(b_px),
    .branch_flush_o(b_bf), .branch_target_o(b_bt), .branch_lane_o(b_bl),
    .mem_valid_o(b_mv), .mem_payload_o(b_mpl), .redirect_cnt_o(b_rc), .squash_cnt_o(b_sc)
  );

  // narrow-counter instance
  logic         c_rst, c_flush, c_pause;
  logic [1:0]   c_v, c_mp, c_lp;
  logic [15:0]  c_pl;
  logic [63:0]  c_tg;
  logic         c_px, c_bf;
  logic [31:0]  c_bt;
  logic [0:0]   c_bl;
  logic [1:0]   c_mv;
  logic [15:0]  c_mpl;
  logic [3:0]   c_rc, c_sc;

  ex_mem_stage_n #(.LANES(2), .PAYLOAD_W(8), .CNT_W(4)) u_dutc (
    .clk(clk), .rst(c_rst), .flush(c_flush), .pause(c_pause),
    .lane_valid_i(c_v), .lane_payload_i(c_pl), .lane_mispred_i(c_mp),
    .lane_target_i(c_tg), .lane_pause_i(c_lp), .pause_ex_o(c_px),
    .branch_flush_o(c_bf), .branch_target_o(c_bt), .branch_lane_o(c_bl),
    .mem_valid_o(c_mv), .mem_payload_o(c_mpl), .redirect_cnt_o(c_rc), .squash_cnt_o(c_sc)
  );

  typedef struct packed {
    logic [1:0] v, mp, lp;
    logic       ps, fl;
    logic [1:0] e_mv;
    logic       e_bf, e_bl, e_px;
    logic [7:0] e_rc, e_sc;
  } vec_t;

  vec_t tbl [12];

  // behavioural model state for the randomized phase
  logic [1:0]   m_mv;
  logic [255:0] m_mpl;
  logic         m_bf, m_pend;
  logic [31:0]  m_bt, m_pt, m_rc, m_sc;
  logic [0:0]   m_bl, m_plane;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst = 0; a_flush = 0; a_pause = 0; a_v = 0; a_mp = 0; a_lp = 0;
    a_pl = {PL1, PL0}; a_tg = {T1, T0};
    b_rst = 0; b_flush = 0; b_pause = 0; b_v = 0; b_mp = 0; b_lp = 0; b_pl = 0; b_tg = 0;
    c_rst = 0; c_flush = 0; c_pause = 0; c_v = 0; c_mp = 0; c_lp = 0; c_pl = 16'hA55A; c_tg = 0;

    tbl[0]  = '{2'b11, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1};
    tbl[1]  = '{2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1};
    tbl[2]  = '{2'b11, 2'b01, 2'b10, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'd2, 8'd2};
    tbl[3]  = '{2'b11, 2'b00, 2'b10, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 8'd2, 8'd2};
    tbl[4]  = '{2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 8'd3, 8'd2};
    tbl[5]  = '{2'b11, 2'b01, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 8'd3, 8'd2};
    tbl[6]  = '{2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8'd3, 8'd2};
    tbl[7]  = '{2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 8'd4, 8'd2};
    tbl[8]  = '{2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd4, 8'd2};
    tbl[9]  = '{2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 8'd5, 8'd2};
    tbl[10] = '{2'b11, 2'b11, 2'b11, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 8'd6, 8'd3};
    tbl[11] = '{2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 8'd6, 8'd3};

    // reset state while reset is held
    #2;
    chk("rst_bf", a_bf, 0);  chk("rst_bt", a_bt, 0);  chk("rst_bl", a_bl, 0);
    chk("rst_mv", a_mv, 0);  chk("rst_mpl", a_mpl, 0);
    chk("rst_rc", a_rc, 0);  chk("rst_sc", a_sc, 0);
    tick(); tick();
    a_rst = 1; b_rst = 1; c_rst = 1;

    // directed table
    for (int i = 0; i < 12; i++) begin
      a_v = tbl[i].v; a_mp = tbl[i].mp; a_lp = tbl[i].lp;
      a_pause = tbl[i].ps; a_flush = tbl[i].fl;
      #1;
      chk($sformatf("tbl%0d_pause_ex", i), a_px, tbl[i].e_px);
      tick();
      $display("tbl %0d: v=%b mp=%b lp=%b pause=%b flush=%b -> mv=%b bf=%b bl=%0d rc=%0d sc=%0d",
               i, tbl[i].v, tbl[i].mp, tbl[i].lp, tbl[i].ps, tbl[i].fl, a_mv, a_bf, a_bl, a_rc, a_sc);
      chk($sformatf("tbl%0d_mv", i), a_mv, tbl[i].e_mv);
      chk($sformatf("tbl%0d_bf", i), a_bf, tbl[i].e_bf);
      chk($sformatf("tbl%0d_bl", i), a_bl, tbl[i].e_bl);
      chk($sformatf("tbl%0d_rc", i), a_rc, tbl[i].e_rc);
      chk($sformatf("tbl%0d_sc", i), a_sc, tbl[i].e_sc);
      chk($sformatf("tbl%0d_mpl", i), a_mpl,
          {tbl[i].e_mv[1] ? PL1 : 128'h0, tbl[i].e_mv[0] ? PL0 : 128'h0});
      if (tbl[i].e_bf) chk($sformatf("tbl%0d_bt", i), a_bt, tbl[i].e_bl ? T1 : T0);
    end

    // mispredict under a 3-cycle stall: parked, lane inputs ignored, then one pulse
    a_v = 2'b11; a_mp = 2'b10; a_tg = {32'h3000_0100, T0}; a_pause = 1; a_lp = 0;
    tick();
    chk("pend_c1_bf", a_bf, 0);
    a_mp = 2'b01; a_tg = {T1, 32'h0BAD_0BAD};
    tick(); chk("pend_c2_bf", a_bf, 0);
    tick(); chk("pend_c3_bf", a_bf, 0);
    a_pause = 0; a_v = 2'b00; a_mp = 2'b00;
    tick();
    $display("pend release: bf=%b bt=%h bl=%0d rc=%0d", a_bf, a_bt, a_bl, a_rc);
    chk("pend_rel_bf", a_bf, 1); chk("pend_rel_bt", a_bt, 32'h3000_0100);
    chk("pend_rel_bl", a_bl, 1); chk("pend_rel_rc", a_rc, 7);
    tick();
    chk("pend_after_bf", a_bf, 0); chk("pend_after_rc", a_rc, 7); chk("pend_after_sc", a_sc, 3);

    // parked redirect discarded by flush
    a_v = 2'b11; a_tg = {T1, T0};
    tick(); chk("pf_mv_pre", a_mv, 2'b11);
    a_mp = 2'b01; a_pause = 1;
    tick(); chk("pf_park_bf", a_bf, 0);
    a_flush = 1; a_pause = 0; a_v = 2'b00; a_mp = 2'b00;
    tick();
    chk("pf_flush_mv", a_mv, 0); chk("pf_flush_bf", a_bf, 0);
    a_flush = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("post-flush %0d: bf=%b rc=%0d sc=%0d", i, a_bf, a_rc, a_sc);
      chk($sformatf("pf_idle%0d_bf", i), a_bf, 0);
    end
    chk("pf_rc", a_rc, 7); chk("pf_sc", a_sc, 3);

    // four lanes, lanes 1 and 2 mispredict: lane 1 wins
    b_v = 4'b1111; b_mp = 4'b0110; b_lp = 4'b1100;
    b_pl = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    b_tg = {32'h4000_0000, 32'h3000_0000, 32'h1C00_01C0, 32'h1000_0000};
    #1;
    chk("l4_pause_ex", b_px, 0);
    tick();
    $display("lanes4: mv=%b bf=%b bl=%0d bt=%h sc=%0d rc=%0d", b_mv, b_bf, b_bl, b_bt, b_sc, b_rc);
    chk("l4_mv", b_mv, 4'b0011); chk("l4_mpl", b_mpl, {32'h0, 16'h2222, 16'h1111});
    chk("l4_sc", b_sc, 2); chk("l4_bl", b_bl, 1); chk("l4_bf", b_bf, 1);
    chk("l4_bt", b_bt, 32'h1C00_01C0); chk("l4_rc", b_rc, 1);
    b_v = 0; b_mp = 0; b_lp = 4'b1000;
    tick();
    chk("l4_bf_off", b_bf, 0);

    // 4-bit counters wrap, then asynchronous reset while a redirect is parked
    c_v = 2'b11; c_mp = 2'b01; c_tg = {T1, T0};
    for (int i = 0; i < 15; i++) tick();
    $display("cnt4 after 15: sc=%0d rc=%0d", c_sc, c_rc);
    chk("c4_sc15", c_sc, 15); chk("c4_rc15", c_rc, 15);
    tick();
    $display("cnt4 after 16: sc=%0d rc=%0d", c_sc, c_rc);
    chk("c4_sc_wrap", c_sc, 0); chk("c4_rc_wrap", c_rc, 0);
    c_pause = 1;
    tick();
    chk("c4_park_bf", c_bf, 0);
    #2 c_rst = 0;
    #1;
    chk("c4_rst_bf", c_bf, 0); chk("c4_rst_bt", c_bt, 0); chk("c4_rst_bl", c_bl, 0);
    chk("c4_rst_mv", c_mv, 0); chk("c4_rst_mpl", c_mpl, 0);
    chk("c4_rst_rc", c_rc, 0); chk("c4_rst_sc", c_sc, 0);
    tick();
    c_rst = 1; c_pause = 0; c_v = 0; c_mp = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("c4_post_rst%0d_bf", i), c_bf, 0);
    end

    // randomized phase against the behavioural model
    a_rst = 0; a_flush = 0; a_pause = 0; a_v = 0; a_mp = 0; a_lp = 0;
    #1;
    chk("rnd_rst_mv", a_mv, 0); chk("rnd_rst_rc", a_rc, 0);
    tick();
    a_rst = 1;
    m_mv = 0; m_mpl = 0; m_bf = 0; m_pend = 0; m_bt = 0; m_pt = 0; m_rc = 0; m_sc = 0;
    m_bl = 0; m_plane = 0;
    for (int n = 0; n < 400; n++) begin
      int win;
      int nsq;
      logic px;
      logic [1:0] killed;
      a_v = 2'($urandom);
      a_mp = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      a_lp = 2'($urandom);
      for (int k = 0; k < 8; k++) a_pl[k*32 +: 32] = $urandom;
      a_tg = {$urandom, $urandom};
      a_pause = ($urandom_range(0, 3) == 0);
      a_flush = ($urandom_range(0, 15) == 0);

      win = -1;
      for (int k = 0; k < 2; k++) if (a_v[k] && a_mp[k] && win < 0) win = k;
      px = 0; nsq = 0;
      for (int k = 0; k < 2; k++) begin
        killed[k] = (win >= 0) && (k > win);
        if (a_v[k] && a_lp[k] && !killed[k]) px = 1;
        if (a_v[k] && killed[k]) nsq++;
      end
      #1;
      chk($sformatf("rnd%0d_pause_ex", n), a_px, px);

      if (a_flush) begin
        m_mv = 0; m_mpl = 0; m_bf = 0; m_pend = 0;
      end else begin
        if (!a_pause) begin
          for (int k = 0; k < 2; k++) begin
            m_mv[k] = a_v[k] && !killed[k];
            m_mpl[k*128 +: 128] = m_mv[k] ? a_pl[k*128 +: 128] : 128'h0;
          end
          m_sc = m_sc + 32'(nsq);
        end
        m_bf = 0;
        if (m_pend) begin
          if (!a_pause) begin
            m_bf = 1; m_bt = m_pt; m_bl = m_plane; m_pend = 0;
          end
        end else if (win >= 0) begin
          if (!a_pause) begin
            m_bf = 1; m_bt = a_tg[win*32 +: 32]; m_bl = 1'(win);
          end else begin
            m_pend = 1; m_pt = a_tg[win*32 +: 32]; m_plane = 1'(win);
          end
        end
        if (m_bf) m_rc = m_rc + 1;
      end

      tick();
      $display("rnd %0d: v=%b mp=%b ps=%b fl=%b -> mv=%b bf=%b bl=%0d rc=%0d sc=%0d",
               n, a_v, a_mp, a_pause, a_flush, a_mv, a_bf, a_bl, a_rc, a_sc);
      chk($sformatf("rnd%0d_mv", n), a_mv, m_mv);
      chk($sformatf("rnd%0d_mpl", n), a_mpl, m_mpl);
      chk($sformatf("rnd%0d_bf", n), a_bf, m_bf);
      chk($sformatf("rnd%0d_bt", n), a_bt, m_bt);
      chk($sformatf("rnd%0d_bl", n), a_bl, m_bl);
      chk($sformatf("rnd%0d_rc", n), a_rc, m_rc);
      chk($sformatf("rnd%0d_sc", n), a_sc, m_sc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
